conc_trace_capture: RTL and testbench

- Per-cycle recorder at the DUT side of the concolic bench. It is the inverse of the opcode-driven stimulus path.
- Each enabled cycle it samples the stimulus byte {__obs, stbi, x_in[5:0]} and the DUT response x_out[5:0].
- Identical consecutive samples are run-length compressed into one record. Records are buffered in a FIFO and drained over a valid/ready interface for dumping or checking.

---
 rtl/conc_trace_capture.sv | 159 +++++++++++++++
 tb/tb_conc_trace_capture.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conc_trace_capture.sv
// conc_trace_capture: per-cycle trace recorder. Samples {obs, stbi, x_in, x_out}
// on every enabled edge, run-length compresses identical consecutive samples
// into one record, and buffers the records in a first-word-fall-through FIFO
// that a consumer drains over a valid/ready interface.
module conc_trace_capture #(
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8,
    parameter int DATA_W = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     obs_i,
    input  logic                     stbi_i,
    input  logic [DATA_W-1:0]        x_in_i,
    input  logic [DATA_W-1:0]        x_out_i,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [DATA_W+1:0]        rec_opcode,
    output logic [DATA_W-1:0]        rec_xout,
    output logic [CNT_W-1:0]         rec_count,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int SAMP_W = 2 * DATA_W + 2;
    localparam int REC_W  = SAMP_W + CNT_W;
    localparam int AW     = $clog2(DEPTH);
    localparam int LVL_W  = AW + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // Pending run: IDLE means no run is being accumulated.
    state_t                r_state;
    logic [SAMP_W-1:0]     r_pend_sample;
    logic [CNT_W-1:0]      r_pend_count;

    // FIFO storage and bookkeeping.
    logic [REC_W-1:0]      r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic                  r_overflow;

    logic [SAMP_W-1:0]     w_sample;
    logic                  w_same;
    logic                  w_sat;
    logic                  w_push;
    logic [REC_W-1:0]      w_push_rec;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_drop;
    logic [REC_W-1:0]      w_head;

    assign w_sample   = {obs_i, stbi_i, x_in_i, x_out_i};
    assign w_same     = (w_sample == r_pend_sample);
    assign w_sat      = (r_pend_count == CNT_MAX);
    assign w_push_rec = {r_pend_sample, r_pend_count};

    // Decide whether the pending run terminates on this edge.
    always_comb begin
        // NOTE: default first so every path assigns w_push and no latch is inferred.
        w_push = 1'b0;
        if (flush) begin
            w_push = (r_state == ST_RUN);
        end else if (en && (r_state == ST_RUN) && (!w_same || w_sat)) begin
            w_push = 1'b1;
        end
    end

    // Capture FSM: accumulate identical samples, reload after each terminated run.
    always_ff @(posedge clock) begin
        // NOTE: state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pend_sample <= '0;
            r_pend_count  <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else if (en) begin
            case (r_state)
                ST_IDLE: begin
                    r_state       <= ST_RUN;
                    r_pend_sample <= w_sample;
                    r_pend_count  <= CNT_ONE;
                end
                ST_RUN: begin
                    if (w_same && !w_sat) begin
                        r_pend_count <= r_pend_count + CNT_ONE;
                    end else begin
                        r_pend_sample <= w_sample;
                        r_pend_count  <= CNT_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A push into a full FIFO only fits if the head leaves on the same edge.
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_FULL);
    assign w_pop   = !w_empty && rec_ready;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    // Record storage write port.
    always_ff @(posedge clock) begin
        // NOTE: storage is not reset; the empty flag gates every read of stale entries.
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_push_rec;
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // First-word-fall-through head, forced to zero while empty.
    assign w_head     = r_mem[r_rd_ptr];
    assign rec_valid  = !w_empty;
    assign rec_opcode = w_empty ? '0 : w_head[REC_W-1 -: (DATA_W + 2)];
    assign rec_xout   = w_empty ? '0 : w_head[CNT_W +: DATA_W];
    assign rec_count  = w_empty ? '0 : w_head[CNT_W-1:0];
    assign level      = r_level;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_conc_trace_capture.sv
// tb_conc_trace_capture: directed stimulus for the trace recorder, checked every
// cycle against a queue-based behavioural model, plus literal spot checks.
module tb_conc_trace_capture;

    localparam int DEPTH  = 16;
    localparam int CNT_W  = 8;
    localparam int DATA_W = 6;
    localparam int CMAX   = 255;

    logic       clock;
    logic       reset;
    logic       en;
    logic       flush;
    logic       obs_i;
    logic       stbi_i;
    logic [5:0] x_in_i;
    logic [5:0] x_out_i;
    logic       rec_valid;
    logic       rec_ready;
    logic [7:0] rec_opcode;
    logic [5:0] rec_xout;
    logic [7:0] rec_count;
    logic [4:0] level;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    conc_trace_capture #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .DATA_W(DATA_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .obs_i     (obs_i),
        .stbi_i    (stbi_i),
        .x_in_i    (x_in_i),
        .x_out_i   (x_out_i),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_opcode(rec_opcode),
        .rec_xout  (rec_xout),
        .rec_count (rec_count),
        .level     (level),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] op;
        logic [5:0] xo;
        int         cnt;
    } rec_t;

    rec_t       m_q[$];
    bit         m_valid = 0;
    logic [7:0] m_op    = '0;
    logic [5:0] m_xo    = '0;
    int         m_cnt   = 0;
    bit         m_ovf   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one clock edge's worth of rules using the inputs as they are now.
    task automatic model_step();
        bit         do_push;
        bit         do_pop;
        rec_t       r;
        logic [7:0] s_op;
        s_op    = {obs_i, stbi_i, x_in_i};
        do_push = 0;
        r       = '{op: m_op, xo: m_xo, cnt: m_cnt};
        if (reset) begin
            m_q.delete();
            m_valid = 0;
            m_ovf   = 0;
            return;
        end
        do_pop = (m_q.size() > 0) && rec_ready;
        if (flush) begin
            do_push = m_valid;
            m_valid = 0;
        end else if (en) begin
            if (m_valid && s_op == m_op && x_out_i == m_xo && m_cnt < CMAX) begin
                m_cnt++;
            end else begin
                do_push = m_valid;
                m_valid = 1;
                m_op    = s_op;
                m_xo    = x_out_i;
                m_cnt   = 1;
            end
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(r);
            else m_ovf = 1;
        end
    endtask

    task automatic compare_all();
        check("valid", rec_valid, m_q.size() != 0);
        check("level", level, m_q.size());
        check("overflow", overflow, m_ovf);
        if (m_q.size() != 0) begin
            check("head_op", rec_opcode, m_q[0].op);
            check("head_xo", rec_xout, m_q[0].xo);
            check("head_cnt", rec_count, m_q[0].cnt);
        end else begin
            check("empty_op", rec_opcode, 0);
            check("empty_xo", rec_xout, 0);
            check("empty_cnt", rec_count, 0);
        end
    endtask

    // Inputs change on the falling edge; the DUT and model both see them at the rising edge.
    task automatic drive(input bit e, input bit f, input logic [7:0] op,
                         input logic [5:0] xo, input bit rdy);
        en        = e;
        flush     = f;
        {obs_i, stbi_i, x_in_i} = op;
        x_out_i   = xo;
        rec_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic step(input bit e, input bit f, input logic [7:0] op,
                        input logic [5:0] xo, input bit rdy);
        drive(e, f, op, xo, rdy);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 8'h00, 6'h00, 0);
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", rec_valid, 0);
        check("rst_level", level, 0);
        check("rst_ovf", overflow, 0);

        // 1: run compression
        for (int i = 0; i < 3; i++) step(1, 0, 8'h41, 6'h05, 0);
        check("s1_level_before", level, 0);
        step(1, 0, 8'h02, 6'h00, 0);
        check("s1_valid", rec_valid, 1);
        check("s1_op", rec_opcode, 8'h41);
        check("s1_xo", rec_xout, 6'h05);
        check("s1_cnt", rec_count, 3);
        check("s1_level", level, 1);

        // 2: flush, then repeated flush is a no-op
        step(0, 1, 8'h00, 6'h00, 0);
        check("s2_level", level, 2);
        step(1, 1, 8'h7F, 6'h3F, 0);
        step(0, 1, 8'h00, 6'h00, 0);
        check("s2_level_again", level, 2);
        step(0, 0, 8'h00, 6'h00, 1);
        check("s2_second_op", rec_opcode, 8'h02);
        check("s2_second_cnt", rec_count, 1);
        step(0, 0, 8'h00, 6'h00, 1);
        check("s2_drained", level, 0);

        // 3: saturation at 255
        for (int i = 0; i < 300; i++) step(1, 0, 8'h80, 6'h3F, 0);
        step(0, 1, 8'h00, 6'h00, 0);
        check("s3_level", level, 2);
        check("s3_cnt_first", rec_count, 255);
        step(0, 0, 8'h00, 6'h00, 1);
        check("s3_cnt_second", rec_count, 45);
        check("s3_op_second", rec_opcode, 8'h80);
        step(0, 0, 8'h00, 6'h00, 1);

        // 4: overflow with consumer stalled
        for (int i = 0; i < 18; i++)
            step(1, 0, (i % 2 == 0) ? 8'hA5 : 8'h5A, (i % 2 == 0) ? 6'h11 : 6'h22, 0);
        step(0, 1, 8'h00, 6'h00, 0);
        check("s4_level", level, 16);
        check("s4_ovf", overflow, 1);
        check("s4_head_op", rec_opcode, 8'hA5);
        check("s4_head_cnt", rec_count, 1);

        // 5: full FIFO with simultaneous push and pop
        step(1, 0, 8'hA5, 6'h11, 0);
        for (int i = 0; i < 10; i++)
            step(1, 0, (i % 2 == 0) ? 8'h5A : 8'hA5, (i % 2 == 0) ? 6'h22 : 6'h11, 1);
        check("s5_level", level, 16);
        check("s5_ovf", overflow, 1);
        for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 6'h00, 1);
        step(0, 1, 8'h00, 6'h00, 1);
        check("s5_push_into_empty", level, 1);
        step(0, 0, 8'h00, 6'h00, 1);
        check("s5_empty", level, 0);

        // 6: reset in mid-operation
        for (int i = 0; i < 6; i++)
            step(1, 0, (i % 2 == 0) ? 8'h13 : 8'h31, 6'h07, 0);
        check("s6_level5", level, 5);
        reset = 1'b1;
        step(1, 0, 8'h13, 6'h07, 0);
        reset = 1'b0;
        check("s6_valid", rec_valid, 0);
        check("s6_level", level, 0);
        check("s6_ovf", overflow, 0);
        step(1, 0, 8'hC3, 6'h2A, 0);
        step(0, 1, 8'h00, 6'h00, 0);
        check("s6_new_op", rec_opcode, 8'hC3);
        check("s6_new_xo", rec_xout, 6'h2A);
        check("s6_new_cnt", rec_count, 1);

        // 7: en gaps hold the run; flush discards its own sample
        step(1, 0, 8'h44, 6'h01, 0);
        step(0, 0, 8'h55, 6'h02, 0);
        step(1, 0, 8'h44, 6'h01, 0);
        step(1, 1, 8'h55, 6'h02, 0);
        step(0, 1, 8'h00, 6'h00, 0);
        check("s7_level", level, 2);
        step(0, 0, 8'h00, 6'h00, 1);
        check("s7_op", rec_opcode, 8'h44);
        check("s7_cnt", rec_count, 2);
        step(0, 0, 8'h00, 6'h00, 1);
        check("s7_empty", level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
